// File: rtl/vdma_axi4_to_axi4s_core.sv
// vdma_axi4_to_axi4s_core
// Reads a 2-D frame from memory over an AXI4 read master and emits it as an
// AXI4-Stream video stream, one pixel per AXI beat.
// Ports:
//   aclk / aresetn        clock, asynchronous active-low reset
//   ctl_*                 enable/update requests, busy flag, frame-start index
//   param_*               next-frame geometry (base, pitch, width, height, max burst-1)
//   monitor_*             shadow geometry currently in use
//   m_axi4_ar* / m_axi4_r*  AXI4 read address / read data channels
//   m_axi4s_*             video stream master (tuser = start of frame, tlast = end of line)
module vdma_axi4_to_axi4s_core #(
  parameter int AXI4_ID_WIDTH    = 6,
  parameter int AXI4_ADDR_WIDTH  = 32,
  parameter int AXI4_DATA_SIZE   = 2,
  parameter int AXI4_LEN_WIDTH   = 8,
  parameter int AXI4S_DATA_WIDTH = 24,
  parameter int INDEX_WIDTH      = 8,
  parameter int STRIDE_WIDTH     = 14,
  parameter int H_WIDTH          = 12,
  parameter int V_WIDTH          = 12,
  localparam int AXI4_DATA_WIDTH = 8 << AXI4_DATA_SIZE
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        ctl_enable,
  input  logic                        ctl_update,
  output logic                        ctl_busy,
  output logic [INDEX_WIDTH-1:0]      ctl_index,
  input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
  input  logic [STRIDE_WIDTH-1:0]     param_stride,
  input  logic [H_WIDTH-1:0]          param_width,
  input  logic [V_WIDTH-1:0]          param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,
  output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
  output logic [STRIDE_WIDTH-1:0]     monitor_stride,
  output logic [H_WIDTH-1:0]          monitor_width,
  output logic [V_WIDTH-1:0]          monitor_height,
  output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,
  output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
  output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
  output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
  output logic [2:0]                  m_axi4_arsize,
  output logic [1:0]                  m_axi4_arburst,
  output logic                        m_axi4_arlock,
  output logic [3:0]                  m_axi4_arcache,
  output logic [2:0]                  m_axi4_arprot,
  output logic [3:0]                  m_axi4_arqos,
  output logic [3:0]                  m_axi4_arregion,
  output logic                        m_axi4_arvalid,
  input  logic                        m_axi4_arready,
  input  logic [AXI4_DATA_WIDTH-1:0]  m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready,
  output logic                        m_axi4s_tuser,
  output logic                        m_axi4s_tlast,
  output logic [AXI4S_DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                        m_axi4s_tvalid,
  input  logic                        m_axi4s_tready
);
  localparam int AW = AXI4_ADDR_WIDTH;
  // common width for beat arithmetic (max burst beats vs pixels left in line)
  localparam int CW = (AXI4_LEN_WIDTH + 1 > H_WIDTH) ? AXI4_LEN_WIDTH + 1 : H_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic                       first_q;
  logic [INDEX_WIDTH-1:0]     idx_q;
  logic [AW-1:0]              sh_addr;
  logic [STRIDE_WIDTH-1:0]    sh_stride;
  logic [H_WIDTH-1:0]         sh_width;
  logic [V_WIDTH-1:0]         sh_height;
  logic [AXI4_LEN_WIDTH-1:0]  sh_arlen;

  // AR side
  logic [H_WIDTH-1:0]         ar_x;
  logic [V_WIDTH-1:0]         ar_y;
  logic [AW-1:0]              line_addr;
  logic                       arvalid_q;

  // R side: own counters and dims, since AR may already be in the next frame
  logic [H_WIDTH-1:0]         rx, r_w;
  logic [V_WIDTH-1:0]         ry, r_h;
  logic [1:0]                 pend_q, pend_d;   // frames started but not fully received

  logic [AW-1:0]              cand_addr;
  logic [STRIDE_WIDTH-1:0]    cand_stride;
  logic [H_WIDTH-1:0]         cand_width;
  logic [V_WIDTH-1:0]         cand_height;
  logic [AXI4_LEN_WIDTH-1:0]  cand_arlen;
  logic                       cand_ok, start;
  logic [CW-1:0]              rem, max_beats, beats;
  logic [H_WIDTH-1:0]         x_sum;
  logic                       ar_fire, line_end, frame_ar_end;
  logic                       r_cnt, r_frame_end;
  logic                       unused_inputs;

  // geometry that a frame starting this cycle would use
  always_comb begin
    cand_addr   = sh_addr;
    cand_stride = sh_stride;
    cand_width  = sh_width;
    cand_height = sh_height;
    cand_arlen  = sh_arlen;
    if (ctl_update || first_q) begin
      cand_addr   = param_addr;
      cand_stride = param_stride;
      cand_width  = param_width;
      cand_height = param_height;
      cand_arlen  = param_arlen;
    end
    cand_ok = (cand_width != '0) && (cand_height != '0);
  end

  // burst sizing: never past the end of the current line
  always_comb begin
    rem          = CW'(sh_width) - CW'(ar_x);
    max_beats    = CW'(sh_arlen) + CW'(1);
    beats        = (rem < max_beats) ? rem : max_beats;
    x_sum        = ar_x + H_WIDTH'(beats);
    ar_fire      = arvalid_q && m_axi4_arready;
    line_end     = (x_sum == sh_width);
    frame_ar_end = ar_fire && line_end && (ar_y == sh_height - V_WIDTH'(1));
    r_cnt        = m_axi4_rvalid && m_axi4_s_tready_w() && (pend_q != 2'd0);
    r_frame_end  = r_cnt && (rx == r_w - H_WIDTH'(1)) && (ry == r_h - V_WIDTH'(1));
  end

  function automatic logic m_axi4_s_tready_w();
    return m_axi4s_tready;
  endfunction

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: if (ctl_enable && cand_ok) begin
        start   = 1'b1;
        state_d = RUN;
      end
      RUN: if (frame_ar_end) begin
        if (ctl_enable && cand_ok) start = 1'b1;   // chain straight into next frame
        else                       state_d = DRAIN;
      end
      DRAIN: if (r_frame_end && pend_q == 2'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pend_d = pend_q + 2'(start) - 2'(r_frame_end);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      idx_q     <= '0;
      sh_addr   <= '0;
      sh_stride <= '0;
      sh_width  <= '0;
      sh_height <= '0;
      sh_arlen  <= '0;
      ar_x      <= '0;
      ar_y      <= '0;
      line_addr <= '0;
      arvalid_q <= 1'b0;
      rx        <= '0;
      ry        <= '0;
      r_w       <= '0;
      r_h       <= '0;
      pend_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (start) begin
        sh_addr   <= cand_addr;
        sh_stride <= cand_stride;
        sh_width  <= cand_width;
        sh_height <= cand_height;
        sh_arlen  <= cand_arlen;
        first_q   <= 1'b0;
        idx_q     <= idx_q + INDEX_WIDTH'(1);
        ar_x      <= '0;
        ar_y      <= '0;
        line_addr <= cand_addr;
        arvalid_q <= 1'b1;
      end else if (ar_fire) begin
        if (frame_ar_end) begin
          arvalid_q <= 1'b0;
        end else if (line_end) begin
          ar_x      <= '0;
          ar_y      <= ar_y + V_WIDTH'(1);
          line_addr <= line_addr + AW'(sh_stride);
        end else begin
          ar_x <= x_sum;
        end
      end

      if (r_cnt) begin
        if (rx == r_w - H_WIDTH'(1)) begin
          rx <= '0;
          ry <= (ry == r_h - V_WIDTH'(1)) ? '0 : ry + V_WIDTH'(1);
        end else begin
          rx <= rx + H_WIDTH'(1);
        end
      end

      // R dims follow the oldest frame still owed data. Assumes AR runs at
      // most one frame ahead of R, which holds for any slave whose read
      // outstanding depth is below a frame.
      if (start && (pend_q == 2'd0 || (pend_q == 2'd1 && r_frame_end))) begin
        r_w <= cand_width;
        r_h <= cand_height;
      end else if (r_frame_end) begin
        r_w <= sh_width;
        r_h <= sh_height;
      end
    end
  end

  assign ctl_busy        = (state_q != IDLE);
  assign ctl_index       = idx_q;
  assign monitor_addr    = sh_addr;
  assign monitor_stride  = sh_stride;
  assign monitor_width   = sh_width;
  assign monitor_height  = sh_height;
  assign monitor_arlen   = sh_arlen;

  assign m_axi4_arid     = '0;
  assign m_axi4_araddr   = line_addr + (AW'(ar_x) << AXI4_DATA_SIZE);
  assign m_axi4_arlen    = AXI4_LEN_WIDTH'(beats - CW'(1));
  assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);
  assign m_axi4_arburst  = 2'b01;
  assign m_axi4_arlock   = 1'b0;
  assign m_axi4_arcache  = 4'b0011;
  assign m_axi4_arprot   = 3'b000;
  assign m_axi4_arqos    = 4'b0000;
  assign m_axi4_arregion = 4'b0000;
  assign m_axi4_arvalid  = arvalid_q;

  // stream is a wire-through of the read data channel
  assign m_axi4_rready   = m_axi4s_tready;
  assign m_axi4s_tvalid  = m_axi4_rvalid;
  assign m_axi4s_tdata   = m_axi4_rdata[AXI4S_DATA_WIDTH-1:0];
  assign m_axi4s_tuser   = (rx == '0) && (ry == '0);
  assign m_axi4s_tlast   = (rx == r_w - H_WIDTH'(1));

  assign unused_inputs   = ^{m_axi4_rresp, m_axi4_rlast, m_axi4_rdata};
endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
module tb_vdma_axi4_to_axi4s_core;
  logic aclk = 1'b0, aresetn = 1'b0, ctl_enable = 1'b0, ctl_update = 1'b0, ctl_busy;
  logic [7:0]  ctl_index;
  logic [31:0] param_addr = '0, monitor_addr;
  logic [13:0] param_stride = '0, monitor_stride;
  logic [11:0] param_width = '0, monitor_width;
  logic [11:0] param_height = '0, monitor_height;
  logic [7:0]  param_arlen = '0, monitor_arlen;
  logic [5:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock, arvalid, arready = 1'b0;
  logic [3:0]  arcache, arqos, arregion;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;
  logic        tuser, tlast, tvalid, tready = 1'b0;
  logic [23:0] tdata;

  always #5 aclk = ~aclk;

  vdma_axi4_to_axi4s_core dut (
    .aclk(aclk), .aresetn(aresetn), .ctl_enable(ctl_enable), .ctl_update(ctl_update),
    .ctl_busy(ctl_busy), .ctl_index(ctl_index),
    .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
    .param_height(param_height), .param_arlen(param_arlen),
    .monitor_addr(monitor_addr), .monitor_stride(monitor_stride), .monitor_width(monitor_width),
    .monitor_height(monitor_height), .monitor_arlen(monitor_arlen),
    .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen), .m_axi4_arsize(arsize),
    .m_axi4_arburst(arburst), .m_axi4_arlock(arlock), .m_axi4_arcache(arcache),
    .m_axi4_arprot(arprot), .m_axi4_arqos(arqos), .m_axi4_arregion(arregion),
    .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
    .m_axi4_rdata(rdata), .m_axi4_rresp(2'b00), .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid),
    .m_axi4_rready(rready),
    .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast), .m_axi4s_tdata(tdata),
    .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [23:0] data; logic user; logic last; } px_t;
  typedef struct { logic [31:0] a; int n; } burst_t;

  ar_t    ar_log[$], exp_ar[$];
  px_t    px_log[$], exp_px[$];
  burst_t arq[$];
  int     r_idx = 0;
  bit     ar_block = 0, rand_tready = 0;
  int     checks = 0, failures = 0;

  // memory slave: each beat returns its own byte address as data
  always @(negedge aclk) begin
    if (!aresetn) begin
      arq.delete(); r_idx = 0; arready = 0; rvalid = 0; rlast = 0; tready = 0;
    end else begin
      arready = ar_block ? 1'b0 : ($urandom_range(0, 3) != 0);
      tready  = rand_tready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (arq.size() > 0) begin
        rvalid = ($urandom_range(0, 3) != 0);
        rdata  = arq[0].a + 32'(r_idx * 4);
        rlast  = (r_idx == arq[0].n - 1);
      end else begin
        rvalid = 0; rlast = 0;
      end
      #1;
      if (arvalid && arready) begin
        arq.push_back('{araddr, int'(arlen) + 1});
        ar_log.push_back('{araddr, arlen});
      end
      if (rvalid && rready) begin
        px_log.push_back('{tdata, tuser, tlast});
        r_idx++;
        if (r_idx == arq[0].n) begin arq.pop_front(); r_idx = 0; end
      end
    end
  end

  // reference: frame raster walked line by line, bursts cut at line end
  task automatic model_frame(input logic [31:0] base, input int stride, input int w, input int h, input int len);
    for (int y = 0; y < h; y++) begin
      logic [31:0] la = base + 32'(y * stride);
      for (int x = 0; x < w; ) begin
        int b = (w - x < len + 1) ? w - x : len + 1;
        exp_ar.push_back('{la + 32'(x * 4), 8'(b - 1)});
        x += b;
      end
      for (int x = 0; x < w; x++)
        exp_px.push_back('{24'(la + 32'(x * 4)), (x == 0 && y == 0), (x == w - 1)});
    end
  endtask

  task automatic set_params(input logic [31:0] a, input int s, input int w, input int h, input int l);
    param_addr = a; param_stride = 14'(s); param_width = 12'(w); param_height = 12'(h); param_arlen = 8'(l);
  endtask

  task automatic clear_logs();
    ar_log.delete(); px_log.delete(); exp_ar.delete(); exp_px.delete();
  endtask

  task automatic start_frame(input bit upd);
    @(negedge aclk); ctl_update = upd; ctl_enable = 1;
    @(negedge aclk); ctl_update = 0; ctl_enable = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (ctl_busy && n < 5000) begin @(negedge aclk); n++; end
    repeat (2) @(negedge aclk);
    if (n >= 5000) begin
      checks++; failures++;
      $display("FAIL %s_timeout busy still %0d after %0d cycles, want 0", name, ctl_busy, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    #2;
    checks++; if (arvalid !== 1'b0)     begin failures++; $display("FAIL reset_arvalid got %0d want 0", arvalid); end
    checks++; if (ctl_busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got %0d want 0", ctl_busy); end
    checks++; if (ctl_index !== 8'd0)   begin failures++; $display("FAIL reset_index got %0d want 0", ctl_index); end
    checks++; if (monitor_addr !== '0)  begin failures++; $display("FAIL reset_monitor_addr got %h want 0", monitor_addr); end
    checks++; if (monitor_width !== '0) begin failures++; $display("FAIL reset_monitor_width got %0d want 0", monitor_width); end
    checks++; if (arcache !== 4'b0011 || arburst !== 2'b01 || arsize !== 3'd2 || arid !== '0)
      begin failures++; $display("FAIL reset_ar_consts got cache=%b burst=%b size=%0d id=%0d want 0011/01/2/0", arcache, arburst, arsize, arid); end
    @(negedge aclk); aresetn = 1;
  endtask

  // runs one frame and compares AR and pixel logs against the model
  task automatic test_frame(input string name, input logic [31:0] a, input int s, input int w,
                            input int h, input int l, input bit upd);
    logic [7:0] idx0 = ctl_index;
    clear_logs();
    set_params(a, s, w, h, l);
    start_frame(upd);
    wait_idle(name);
    model_frame(a, s, w, h, l);
    checks++;
    if (ar_log.size() != exp_ar.size() || px_log.size() != exp_px.size()) begin
      failures++;
      $display("FAIL %s_counts got ar=%0d px=%0d want ar=%0d px=%0d", name, ar_log.size(), px_log.size(), exp_ar.size(), exp_px.size());
    end else begin
      foreach (exp_ar[i]) begin checks++; if (ar_log[i] !== exp_ar[i]) begin failures++; $display("FAIL %s_ar[%0d] got %h want %h", name, i, ar_log[i], exp_ar[i]); end end
      foreach (exp_px[i]) begin checks++; if (px_log[i] !== exp_px[i]) begin failures++; $display("FAIL %s_px[%0d] got %h want %h", name, i, px_log[i], exp_px[i]); end end
    end
    checks++; if (ctl_index !== idx0 + 8'd1) begin failures++; $display("FAIL %s_index got %0d want %0d", name, ctl_index, idx0 + 8'd1); end
  endtask

  task automatic test_ar_stall();
    ar_block = 1;
    clear_logs();
    set_params(32'h0000_2000, 64, 5, 1, 3);
    start_frame(1);
    repeat (5) begin
      #2;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h2000 || arlen !== 8'd3) begin
        failures++; $display("FAIL stall_hold got v=%0d a=%h l=%0d want 1/00002000/3", arvalid, araddr, arlen);
      end
      @(negedge aclk);
    end
    ar_block = 0;
    wait_idle("stall");
    model_frame(32'h2000, 64, 5, 1, 3);
    checks++; if (ar_log.size() != 2 || ar_log[0] !== exp_ar[0] || ar_log[1] !== exp_ar[1])
      begin failures++; $display("FAIL stall_ar got n=%0d want 2 bursts 2000/3 2010/0", ar_log.size()); end
  endtask

  task automatic test_passthrough();
    int seen = 0;
    rand_tready = 1;
    set_params(32'h0000_3000, 128, 12, 3, 3);
    start_frame(1);
    while (ctl_busy && seen < 3000) begin
      #2;
      checks++;
      if (rready !== tready || tvalid !== rvalid || (rvalid && tdata !== rdata[23:0])) begin
        failures++; $display("FAIL passthru got rready=%0d tvalid=%0d tdata=%h want %0d/%0d/%h", rready, tvalid, tdata, tready, rvalid, rdata[23:0]);
      end
      @(negedge aclk); seen++;
    end
    wait_idle("passthru");
  endtask

  task automatic test_random();
    rand_tready = 1;
    for (int k = 0; k < 6; k++) begin
      int w = $urandom_range(1, 9), h = $urandom_range(1, 3), l = $urandom_range(0, 3);
      int s = w * 4 + 4 * $urandom_range(0, 16);
      logic [31:0] a = $urandom & 32'hFFFF_FFFC;
      test_frame("random", a, s, w, h, l, 1);
    end
    rand_tready = 0;
  endtask

  task automatic test_shadow();
    test_frame("shadow_a", 32'h0000_4000, 32, 3, 2, 1, 1);
    test_frame("shadow_keep", 32'h0000_4000, 32, 3, 2, 1, 0);
    param_addr = 32'h0000_5000;   // ignored, no update
    clear_logs(); start_frame(0); wait_idle("shadow_keep2");
    checks++; if (ar_log.size() == 0 || ar_log[0].addr !== 32'h4000) begin failures++; $display("FAIL shadow_keep_base got %h want 00004000", ar_log.size() ? ar_log[0].addr : 32'hX); end
    checks++; if (monitor_addr !== 32'h4000) begin failures++; $display("FAIL shadow_monitor_old got %h want 00004000", monitor_addr); end
    test_frame("shadow_new", 32'h0000_5000, 32, 3, 2, 1, 1);
    checks++; if (monitor_addr !== 32'h5000) begin failures++; $display("FAIL shadow_monitor_new got %h want 00005000", monitor_addr); end
  endtask

  task automatic test_zero_size();
    logic [7:0] idx0 = ctl_index;
    set_params(32'h6000, 16, 0, 2, 1);
    @(negedge aclk); ctl_update = 1; ctl_enable = 1;
    repeat (4) @(negedge aclk);
    ctl_update = 0; ctl_enable = 0;
    #2;
    checks++; if (ctl_busy !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL zero_busy got busy=%0d arvalid=%0d want 0/0", ctl_busy, arvalid); end
    checks++; if (ctl_index !== idx0) begin failures++; $display("FAIL zero_index got %0d want %0d", ctl_index, idx0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] idx0 = ctl_index;
    int n = 0;
    clear_logs();
    rand_tready = 1;
    set_params(32'h0000_7000, 48, 5, 2, 2);
    @(negedge aclk); ctl_update = 1; ctl_enable = 1;
    @(negedge aclk); ctl_update = 0;
    while (ctl_index != idx0 + 8'd2 && n < 2000) begin @(negedge aclk); n++; end
    ctl_enable = 0;
    wait_idle("b2b");
    rand_tready = 0;
    model_frame(32'h7000, 48, 5, 2, 2);
    model_frame(32'h7000, 48, 5, 2, 2);
    checks++; if (ctl_index !== idx0 + 8'd2) begin failures++; $display("FAIL b2b_index got %0d want %0d", ctl_index, idx0 + 8'd2); end
    checks++;
    if (ar_log.size() != exp_ar.size() || px_log.size() != exp_px.size()) begin
      failures++; $display("FAIL b2b_counts got ar=%0d px=%0d want ar=%0d px=%0d", ar_log.size(), px_log.size(), exp_ar.size(), exp_px.size());
    end else begin
      foreach (exp_ar[i]) begin checks++; if (ar_log[i] !== exp_ar[i]) begin failures++; $display("FAIL b2b_ar[%0d] got %h want %h", i, ar_log[i], exp_ar[i]); end end
      foreach (exp_px[i]) begin checks++; if (px_log[i] !== exp_px[i]) begin failures++; $display("FAIL b2b_px[%0d] got %h want %h", i, px_log[i], exp_px[i]); end end
    end
  endtask

  task automatic test_reset_mid();
    set_params(32'h0000_8000, 64, 8, 3, 1);
    start_frame(1);
    repeat (6) @(negedge aclk);
    aresetn = 0;
    #2;
    checks++; if (arvalid !== 1'b0 || ctl_busy !== 1'b0 || ctl_index !== 8'd0)
      begin failures++; $display("FAIL midreset got arvalid=%0d busy=%0d index=%0d want 0/0/0", arvalid, ctl_busy, ctl_index); end
    repeat (2) @(negedge aclk);
    aresetn = 1;
    repeat (2) @(negedge aclk);
    test_frame("midreset_restart", 32'h0000_8000, 64, 8, 3, 1, 0);
  endtask

  initial begin
    test_reset();
    test_frame("basic", 32'h0000_1000, 32'h100, 4, 2, 1, 1);
    test_frame("short_tail", 32'h0000_1000, 32'h100, 3, 2, 1, 1);
    test_ar_stall();
    test_passthrough();
    test_random();
    test_shadow();
    test_zero_size();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vdma_axi4_to_axi4s_core.md
VDMA_AXI4_TO_AXI4S_CORE -- requirements
Module: vdma_axi4_to_axi4s_core

Interface
REQ-001 AXI4_ID_WIDTH, 6, ID width.
REQ-002 AXI4_ADDR_WIDTH, 32, address width.
REQ-003 AXI4_DATA_SIZE, 2, log2 bytes per beat; AXI4_DATA_WIDTH = 8<<AXI4_DATA_SIZE.
REQ-004 AXI4_LEN_WIDTH, 8, burst length field width.
REQ-005 AXI4S_DATA_WIDTH, 24, pixel width, <= AXI4_DATA_WIDTH.
REQ-006 INDEX_WIDTH, 8; STRIDE_WIDTH, 14; H_WIDTH, 12; V_WIDTH, 12: counter and parameter widths.
REQ-007 aclk  in  1  sole clock.
REQ-008 aresetn  in  1  asynchronous active-low reset.
REQ-009 ctl_enable  in  1  run request.
REQ-010 ctl_update  in  1  adopt param_* at next frame start.
REQ-011 ctl_busy  out  1  frame in progress.
REQ-012 ctl_index  out  INDEX_WIDTH  frame-start counter.
REQ-013 param_addr / param_stride / param_width / param_height / param_arlen  in  ADDR / STRIDE / H / V / LEN  frame base, line pitch in bytes, pixels per line, lines, max burst beats minus 1.
REQ-014 monitor_addr / monitor_stride / monitor_width / monitor_height / monitor_arlen  out  same widths  active shadow copy.
REQ-015 m_axi4_arid, araddr, arlen, arvalid  out; arready  in  AXI4 read address channel.
REQ-016 m_axi4_arburst=INCR, arsize=AXI4_DATA_SIZE, arcache=4'b0011, arprot=0, arlock=0, arqos=0, arregion=0, arid=0  out  constants.
REQ-017 m_axi4_rdata, rresp, rlast, rvalid  in; rready  out  AXI4 read data channel.
REQ-018 m_axi4s_tuser[0], tlast, tdata[AXI4S_DATA_WIDTH], tvalid  out; tready  in  video stream master.

Function
REQ-019 One pixel per AXI beat; tdata = rdata[AXI4S_DATA_WIDTH-1:0]; rresp ignored.
REQ-020 States IDLE, RUN, DRAIN; in IDLE, ctl_enable=1 and nonzero shadow width/height -> RUN and increment ctl_index.
REQ-021 Frame start: if ctl_update=1 or first frame since reset, shadow <= param_*; else shadow retained.
REQ-022 Frame start with shadow width or height zero: no frame starts, ctl_index does not increment, ctl_busy stays 0.
REQ-023 AR generator: line address = base + y*stride; burst beats = min(arlen+1, pixels remaining in line); next address += beats<<AXI4_DATA_SIZE; no burst crosses a line end.
REQ-024 arvalid/araddr/arlen held stable until arready; back-to-back issue allowed (no idle cycle required).
REQ-025 R path combinational pass-through: tvalid = rvalid, rready = tready; no buffering.
REQ-026 R-side x/y counters advance on rvalid&rready; tuser=1 only on x=0,y=0; tlast=1 on x=width-1 (independent of rlast).
REQ-027 After final AR of a frame: ctl_enable=1 -> next frame starts on AR side immediately (REQ-021 applies); ctl_enable=0 -> DRAIN.
REQ-028 DRAIN -> IDLE when last pixel of frame transfers; ctl_busy = 1 in RUN and DRAIN.
REQ-029 ctl_enable deassert mid-frame: current frame completes; no abort.
REQ-030 ctl_index wraps modulo 2^INDEX_WIDTH.
REQ-031 Address arithmetic modulo 2^AXI4_ADDR_WIDTH; no 4KB-boundary check (software aligns stride/base).

Reset
REQ-032 aresetn=0 at any time, including mid-burst: state IDLE, arvalid=0, ctl_busy=0, ctl_index=0, counters 0, monitor_*=0, first-frame flag set; rready/tvalid follow REQ-025.

Verification
REQ-033 addr=0x1000, stride=0x100, width=4, height=2, arlen=1, enable -> AR 0x1000/1, 0x1008/1, 0x1100/1, 0x1108/1; tuser on beat 0, tlast on beats 3 and 7; ctl_index 0->1.
REQ-034 width=3, arlen=1 -> per line bursts len 1 then len 0 at +8.
REQ-035 arready low 5 cycles -> araddr/arlen stable, arvalid held high.
REQ-036 tready toggled randomly -> rready mirrors tready; pixel order and tuser/tlast positions unchanged.
REQ-037 param_addr changed with ctl_update=0 -> next frame reuses old base; with ctl_update=1 -> new base, monitor_addr updates.
REQ-038 aresetn low mid-frame -> arvalid=0, ctl_busy=0, ctl_index=0 same cycle; re-enable restarts at base.
